// File: rtl/fm_tuner_pkg.sv
// Shared definitions for the FM station tuner.
// Contents:
//   CODE_W, FREQ_MIN/MAX/RESET  frequency code range in 100 kHz units, plus BCD copies
//   preset_t / preset_entry()   preset table of {code, bcd} pairs (up to 10 entries)
//   SEG7 / seg7()               seven-segment patterns, active-high, bit0 = segment a
//   k_step()                    rounded DDS phase increment for one 100 kHz step
//   tuner_state_e               control FSM state encoding
package fm_tuner_pkg;

    localparam int unsigned CODE_W = 11;

    localparam logic [CODE_W-1:0] FREQ_MIN   = 11'd875;
    localparam logic [CODE_W-1:0] FREQ_MAX   = 11'd1080;
    localparam logic [CODE_W-1:0] FREQ_RESET = 11'd1000;

    localparam logic [15:0] BCD_MIN   = 16'h0875;
    localparam logic [15:0] BCD_MAX   = 16'h1080;
    localparam logic [15:0] BCD_RESET = 16'h1000;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDone
    } tuner_state_e;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [15:0]       bcd;
    } preset_t;

    // Digits 9 down to 0; element [d] is the pattern for digit d.
    localparam logic [9:0][6:0] SEG7 = {
        7'h6f, 7'h7f, 7'h07, 7'h7d, 7'h6d, 7'h66, 7'h4f, 7'h5b, 7'h06, 7'h3f
    };

    function automatic logic [6:0] seg7(input logic [3:0] d);
        return (d <= 4'd9) ? SEG7[d] : 7'h00;
    endfunction

    function automatic preset_t preset_entry(input logic [3:0] idx);
        preset_t p;
        unique case (idx)
            4'd0:    p = '{code: 11'd877,  bcd: 16'h0877};
            4'd1:    p = '{code: 11'd893,  bcd: 16'h0893};
            4'd2:    p = '{code: 11'd937,  bcd: 16'h0937};
            4'd3:    p = '{code: 11'd981,  bcd: 16'h0981};
            4'd4:    p = '{code: 11'd1079, bcd: 16'h1079};
            4'd5:    p = '{code: 11'd900,  bcd: 16'h0900};
            4'd6:    p = '{code: 11'd950,  bcd: 16'h0950};
            4'd7:    p = '{code: 11'd1000, bcd: 16'h1000};
            4'd8:    p = '{code: 11'd1035, bcd: 16'h1035};
            4'd9:    p = '{code: 11'd1060, bcd: 16'h1060};
            default: p = '{code: FREQ_RESET, bcd: BCD_RESET};
        endcase
        return p;
    endfunction

    // round(2^width * 1e5 / f_ref)
    function automatic longint unsigned k_step(input int unsigned width,
                                               input longint unsigned f_ref);
        longint unsigned num;
        num = (64'd1 << width) * 64'd100000;
        return (num + f_ref / 2) / f_ref;
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Sequential shift-add multiplier: CODE_W-bit multiplier times WIDTH-bit multiplicand,
// one multiplier bit per cycle, product truncated to WIDTH bits.
// Ports:
//   clk_i, reset_i    clock, synchronous active-high reset (aborts a running multiply)
//   start_i           load operands and begin (ignored reset aside, always restarts)
//   multiplier_i      CODE_W-bit multiplier
//   multiplicand_i    WIDTH-bit multiplicand
//   product_o         running sum; final product is valid while done_o is high
//   done_o            high during the last iteration cycle
module shift_add_mul
    import fm_tuner_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [CODE_W-1:0] multiplier_i,
    input  logic [WIDTH-1:0]  multiplicand_i,
    output logic [WIDTH-1:0]  product_o,
    output logic              done_o
);

    logic [WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]  mcand_q;
    logic [CODE_W-1:0] mplier_q;
    logic [3:0]        cnt_q;
    logic              run_q;
    logic [WIDTH-1:0]  sum;

    assign sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    // The final sum is exposed combinationally so the caller can capture it on the
    // same edge that completes the last iteration.
    assign product_o = sum;
    assign done_o    = run_q && (cnt_q == 4'd1);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (start_i) begin
            acc_q    <= '0;
            mcand_q  <= multiplicand_i;
            mplier_q <= multiplier_i;
            cnt_q    <= 4'(CODE_W);
            run_q    <= 1'b1;
        end else if (run_q) begin
            acc_q    <= sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/station_tuner.sv
// FM station tuner: steps 87.5-108.0 MHz in 100 kHz units from up/down keys, loads
// presets from one-hot switches, drives the DDS reload constant k and a 4-digit display.
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   preset_sel_i     one-hot preset request (lowest set bit wins), 0 = none
//   key_up_i         step-up key, debounced level
//   key_down_i       step-down key, debounced level
//   hex_o            active-low seven-segment digits, hex_o[3] most significant
//   k_o              DDS phase reload constant = code * K_STEP
//   k_update_o       one-cycle pulse in the cycle k_o first shows a new value
//   busy_o           preset/wrap multiply in progress
// Optional feature: define FM_TUNER_AUTO_REPEAT_EN for key auto-repeat.
module station_tuner
    import fm_tuner_pkg::*;
#(
    parameter int unsigned WIDTH_DDS     = 32,
    parameter int unsigned F_REF_HZ      = 240000000,
    parameter int unsigned NUM_PRESETS   = 5,
    parameter int unsigned REPEAT_DELAY  = 24000000,
    parameter int unsigned REPEAT_PERIOD = 4800000
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [NUM_PRESETS-1:0] preset_sel_i,
    input  logic                   key_up_i,
    input  logic                   key_down_i,
    output logic [3:0][6:0]        hex_o,
    output logic [WIDTH_DDS-1:0]   k_o,
    output logic                   k_update_o,
    output logic                   busy_o
);

    localparam logic [WIDTH_DDS-1:0] K_STEP  = WIDTH_DDS'(k_step(WIDTH_DDS, F_REF_HZ));
    localparam logic [WIDTH_DDS-1:0] K_RESET =
        WIDTH_DDS'(k_step(WIDTH_DDS, F_REF_HZ) * 64'(FREQ_RESET));

    if (NUM_PRESETS == 0 || NUM_PRESETS > 10) begin : g_bad_presets
        $error("NUM_PRESETS must be 1..10");
    end
    if (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_PERIOD must be nonzero");
    end

    tuner_state_e state_q, state_d;

    logic [CODE_W-1:0]      code_q, code_d;
    logic [15:0]            bcd_q, bcd_d;
    logic [WIDTH_DDS-1:0]   k_q, k_d;
    logic                   k_upd_q, k_upd_d;
    logic [CODE_W-1:0]      ld_code_q, ld_code_d;
    logic [15:0]            ld_bcd_q, ld_bcd_d;
    logic                   pend_q, pend_d;
    logic [NUM_PRESETS-1:0] pend_sel_q, pend_sel_d;

    // Input samples: *_s_q is the current sample, *_p_q the one before it.
    logic                   up_s_q, up_p_q, dn_s_q, dn_p_q;
    logic [NUM_PRESETS-1:0] sel_q, prev_sel_q;

    logic                   sel_req;
    logic                   step_up, step_dn;
    logic                   rpt_up, rpt_dn;
    logic [NUM_PRESETS-1:0] src_sel;
    logic [3:0]             preset_idx;
    preset_t                preset;
    logic                   load_req;
    logic [CODE_W-1:0]      load_code;
    logic [15:0]            load_bcd;
    logic [WIDTH_DDS-1:0]   mul_product;
    logic                   mul_done;

    assign sel_req = (sel_q != prev_sel_q) && (sel_q != '0);

`ifdef FM_TUNER_AUTO_REPEAT_EN
    logic [31:0] rpt_cnt_q;
    logic        rpt_phase_q;
    logic        rpt_held;
    logic [31:0] rpt_limit;
    logic        rpt_fire;

    // Only a single held key repeats, and never while a load is running.
    assign rpt_held  = (up_s_q ^ dn_s_q) && (state_q == StIdle);
    assign rpt_limit = rpt_phase_q ? 32'(REPEAT_PERIOD) : 32'(REPEAT_DELAY);
    assign rpt_fire  = rpt_held && (rpt_cnt_q == rpt_limit);
    assign rpt_up    = rpt_fire & up_s_q;
    assign rpt_dn    = rpt_fire & dn_s_q;

    always_ff @(posedge clk_i) begin
        if (reset_i || !rpt_held) begin
            rpt_cnt_q   <= '0;
            rpt_phase_q <= 1'b0;
        end else if (rpt_fire) begin
            rpt_cnt_q   <= 32'd1;
            rpt_phase_q <= 1'b1;
        end else begin
            rpt_cnt_q   <= rpt_cnt_q + 32'd1;
        end
    end
`else
    assign rpt_up = 1'b0;
    assign rpt_dn = 1'b0;
`endif

    assign step_up = (up_s_q & ~up_p_q) | rpt_up;
    assign step_dn = (dn_s_q & ~dn_p_q) | rpt_dn;

    // A fresh request overrides anything pending: latest value wins.
    assign src_sel = sel_req ? sel_q : pend_sel_q;

    always_comb begin
        preset_idx = '0;
        for (int i = NUM_PRESETS - 1; i >= 0; i--) begin
            if (src_sel[i]) begin
                preset_idx = 4'(i);
            end
        end
    end

    assign preset = preset_entry(preset_idx);

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        bcd_d      = bcd_q;
        k_d        = k_q;
        k_upd_d    = 1'b0;
        ld_code_d  = ld_code_q;
        ld_bcd_d   = ld_bcd_q;
        pend_d     = pend_q;
        pend_sel_d = pend_sel_q;
        load_req   = 1'b0;
        load_code  = preset.code;
        load_bcd   = preset.bcd;

        unique case (state_q)
            StIdle: begin
                if (sel_req || pend_q) begin
                    load_req = 1'b1;
                    pend_d   = 1'b0;
                end else if (step_up && !step_dn) begin
                    if (code_q < FREQ_MAX) begin
                        code_d  = code_q + 11'd1;
                        bcd_d   = bcd_inc(bcd_q);
                        k_d     = k_q + K_STEP;
                        k_upd_d = 1'b1;
                    end else begin
                        load_req  = 1'b1;
                        load_code = FREQ_MIN;
                        load_bcd  = BCD_MIN;
                    end
                end else if (step_dn && !step_up) begin
                    if (code_q > FREQ_MIN) begin
                        code_d  = code_q - 11'd1;
                        bcd_d   = bcd_dec(bcd_q);
                        k_d     = k_q - K_STEP;
                        k_upd_d = 1'b1;
                    end else begin
                        load_req  = 1'b1;
                        load_code = FREQ_MAX;
                        load_bcd  = BCD_MAX;
                    end
                end
                if (load_req) begin
                    ld_code_d = load_code;
                    ld_bcd_d  = load_bcd;
                    state_d   = StMul;
                end
            end
            StMul: begin
                if (sel_req) begin
                    pend_d     = 1'b1;
                    pend_sel_d = sel_q;
                end
                // code, bcd and k switch together so k stays consistent with code.
                if (mul_done) begin
                    k_d     = mul_product;
                    code_d  = ld_code_q;
                    bcd_d   = ld_bcd_q;
                    k_upd_d = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (sel_req) begin
                    pend_d     = 1'b1;
                    pend_sel_d = sel_q;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            code_q     <= FREQ_RESET;
            bcd_q      <= BCD_RESET;
            k_q        <= K_RESET;
            k_upd_q    <= 1'b0;
            ld_code_q  <= FREQ_RESET;
            ld_bcd_q   <= BCD_RESET;
            pend_q     <= 1'b0;
            pend_sel_q <= '0;
            up_s_q     <= 1'b0;
            up_p_q     <= 1'b0;
            dn_s_q     <= 1'b0;
            dn_p_q     <= 1'b0;
            sel_q      <= '0;
            prev_sel_q <= '0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            bcd_q      <= bcd_d;
            k_q        <= k_d;
            k_upd_q    <= k_upd_d;
            ld_code_q  <= ld_code_d;
            ld_bcd_q   <= ld_bcd_d;
            pend_q     <= pend_d;
            pend_sel_q <= pend_sel_d;
            up_s_q     <= key_up_i;
            up_p_q     <= up_s_q;
            dn_s_q     <= key_down_i;
            dn_p_q     <= dn_s_q;
            sel_q      <= preset_sel_i;
            prev_sel_q <= sel_q;
        end
    end

    shift_add_mul #(
        .WIDTH (WIDTH_DDS)
    ) u_mul (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .start_i        (load_req),
        .multiplier_i   (load_code),
        .multiplicand_i (K_STEP),
        .product_o      (mul_product),
        .done_o         (mul_done)
    );

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hex_o[i] = ~seg7(bcd_q[4*i +: 4]);
        end
        // Leading-zero blanking on the hundreds-of-MHz digit.
        if (bcd_q[15:12] == 4'd0) begin
            hex_o[3] = 7'h7f;
        end
    end

    assign k_o        = k_q;
    assign k_update_o = k_upd_q;
    assign busy_o     = (state_q == StMul);

endmodule

// File: tb/tb_station_tuner.sv
// Directed self-checking bench for station_tuner with default parameters.
module tb_station_tuner;

    localparam int unsigned W  = 32;
    localparam int unsigned NP = 5;

    localparam logic [W-1:0] K1000 = 32'd1789570000;
    localparam logic [W-1:0] K999  = 32'd1787780430;
    localparam logic [W-1:0] K1079 = 32'd1930946030;
    localparam logic [W-1:0] K1080 = 32'd1932735600;
    localparam logic [W-1:0] K875  = 32'd1565873750;
    localparam logic [W-1:0] K937  = 32'd1676827090;
    localparam logic [W-1:0] K893  = 32'd1598086010;

    logic            clk = 1'b0;
    logic            reset;
    logic [NP-1:0]   preset_sel;
    logic            key_up;
    logic            key_down;
    logic [3:0][6:0] hex;
    logic [W-1:0]    k;
    logic            k_update;
    logic            busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    station_tuner dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .preset_sel_i (preset_sel),
        .key_up_i     (key_up),
        .key_down_i   (key_down),
        .hex_o        (hex),
        .k_o          (k),
        .k_update_o   (k_update),
        .busy_o       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        logic [3:0][6:0] eh;
        eh = {7'h79, 7'h40, 7'h40, 7'h40};
        reset = 1'b1; preset_sel = '0; key_up = 1'b0; key_down = 1'b0;
        ticks(2);
        checks++; if (k !== K1000) begin errors++; $display("FAIL reset_k got %0d want %0d", k, K1000); end
        checks++; if (hex !== eh) begin errors++; $display("FAIL reset_hex got %h want %h", hex, eh); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (k_update !== 1'b0) begin errors++; $display("FAIL reset_kupd got %b want 0", k_update); end
        reset = 1'b0;
        ticks(2);
        checks++; if (k !== K1000) begin errors++; $display("FAIL reset_hold_k got %0d want %0d", k, K1000); end
    endtask

    task automatic test_step_down();
        logic [3:0][6:0] eh;
        eh = {7'h7f, 7'h10, 7'h10, 7'h10};
        key_down = 1'b1;
        tick();
        checks++; if (k !== K1000 || k_update !== 1'b0) begin
            errors++; $display("FAIL step_early got k=%0d upd=%b want k=%0d upd=0", k, k_update, K1000);
        end
        tick();
        checks++; if (k !== K999) begin errors++; $display("FAIL step_k got %0d want %0d", k, K999); end
        checks++; if (k_update !== 1'b1) begin errors++; $display("FAIL step_kupd got %b want 1", k_update); end
        checks++; if (hex !== eh) begin errors++; $display("FAIL step_hex got %h want %h", hex, eh); end
        key_down = 1'b0;
        tick();
        checks++; if (k_update !== 1'b0 || k !== K999) begin
            errors++; $display("FAIL step_pulse got upd=%b k=%0d want upd=0 k=%0d", k_update, k, K999);
        end
        tick();
    endtask

    task automatic test_preset();
        logic [3:0][6:0] eh;
        int bad;
        eh = {7'h79, 7'h40, 7'h78, 7'h10};
        bad = 0;
        preset_sel = 5'b10000;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL preset_pre_busy got %b want 0", busy); end
        for (int i = 0; i < 11; i++) begin
            tick();
            if (busy !== 1'b1 || k !== K999 || k_update !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL preset_mul_window got %0d bad cycles want 0", bad); end
        tick();
        checks++; if (k !== K1079) begin errors++; $display("FAIL preset_k got %0d want %0d", k, K1079); end
        checks++; if (k_update !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL preset_done got upd=%b busy=%b want upd=1 busy=0", k_update, busy);
        end
        checks++; if (hex !== eh) begin errors++; $display("FAIL preset_hex got %h want %h", hex, eh); end
        tick();
        checks++; if (k_update !== 1'b0) begin errors++; $display("FAIL preset_pulse got %b want 0", k_update); end
    endtask

    task automatic test_wrap_up();
        logic [3:0][6:0] eh;
        int n;
        eh = {7'h7f, 7'h00, 7'h78, 7'h12};
        key_up = 1'b1; ticks(2); key_up = 1'b0; ticks(2);
        checks++; if (k !== K1080) begin errors++; $display("FAIL wrap_up_1080 got %0d want %0d", k, K1080); end
        key_up = 1'b1;
        ticks(2);
        key_up = 1'b0;
        checks++; if (busy !== 1'b1 || k !== K1080) begin
            errors++; $display("FAIL wrap_up_busy got busy=%b k=%0d want busy=1 k=%0d", busy, k, K1080);
        end
        n = 0;
        while (k_update !== 1'b1 && n < 20) begin tick(); n++; end
        checks++; if (k_update !== 1'b1) begin errors++; $display("FAIL wrap_up_timeout got no k_update want pulse"); end
        checks++; if (k !== K875) begin errors++; $display("FAIL wrap_up_k got %0d want %0d", k, K875); end
        checks++; if (hex !== eh) begin errors++; $display("FAIL wrap_up_hex got %h want %h", hex, eh); end
        ticks(2);
    endtask

    task automatic test_wrap_down();
        logic [3:0][6:0] eh;
        int n;
        eh = {7'h79, 7'h40, 7'h00, 7'h40};
        key_down = 1'b1;
        ticks(2);
        key_down = 1'b0;
        n = 0;
        while (k_update !== 1'b1 && n < 20) begin tick(); n++; end
        checks++; if (k_update !== 1'b1) begin errors++; $display("FAIL wrap_down_timeout got no k_update want pulse"); end
        checks++; if (k !== K1080) begin errors++; $display("FAIL wrap_down_k got %0d want %0d", k, K1080); end
        checks++; if (hex !== eh) begin errors++; $display("FAIL wrap_down_hex got %h want %h", hex, eh); end
        ticks(2);
    endtask

    task automatic test_pending();
        logic [3:0][6:0] eh;
        int pulses;
        eh = {7'h7f, 7'h10, 7'h30, 7'h78};
        pulses = 0;
        preset_sel = 5'b00001;
        for (int i = 0; i < 60; i++) begin
            if (i == 3) preset_sel = 5'b00100;
            if (i == 4) key_up = 1'b1;
            if (i == 6) key_up = 1'b0;
            tick();
            if (k_update === 1'b1) pulses++;
        end
        checks++; if (pulses != 2) begin errors++; $display("FAIL pending_pulses got %0d want 2", pulses); end
        checks++; if (k !== K937) begin errors++; $display("FAIL pending_k got %0d want %0d", k, K937); end
        checks++; if (hex !== eh) begin errors++; $display("FAIL pending_hex got %h want %h", hex, eh); end
    endtask

    task automatic test_multi_bit();
        logic [3:0][6:0] eh;
        int n;
        eh = {7'h7f, 7'h00, 7'h10, 7'h30};
        preset_sel = 5'b01010;
        n = 0;
        tick();
        while (k_update !== 1'b1 && n < 20) begin tick(); n++; end
        checks++; if (k_update !== 1'b1) begin errors++; $display("FAIL multi_timeout got no k_update want pulse"); end
        checks++; if (k !== K893) begin errors++; $display("FAIL multi_k got %0d want %0d", k, K893); end
        checks++; if (hex !== eh) begin errors++; $display("FAIL multi_hex got %h want %h", hex, eh); end
        ticks(2);
    endtask

    task automatic test_both_keys();
        int act;
        act = 0;
        key_up = 1'b1; key_down = 1'b1; preset_sel = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (k_update === 1'b1 || busy === 1'b1) act++;
        end
        key_up = 1'b0; key_down = 1'b0;
        ticks(2);
        checks++; if (act != 0) begin errors++; $display("FAIL both_keys_activity got %0d want 0", act); end
        checks++; if (k !== K893) begin errors++; $display("FAIL both_keys_k got %0d want %0d", k, K893); end
    endtask

    task automatic test_reset_mid_mul();
        logic [3:0][6:0] eh;
        int act;
        eh = {7'h79, 7'h40, 7'h40, 7'h40};
        act = 0;
        preset_sel = 5'b00001;
        ticks(2);
        ticks(4);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mul_busy got %b want 1", busy); end
        reset = 1'b1; preset_sel = '0;
        tick();
        checks++; if (k !== K1000) begin errors++; $display("FAIL rst_mul_k got %0d want %0d", k, K1000); end
        checks++; if (busy !== 1'b0 || k_update !== 1'b0) begin
            errors++; $display("FAIL rst_mul_flags got busy=%b upd=%b want 0 0", busy, k_update);
        end
        checks++; if (hex !== eh) begin errors++; $display("FAIL rst_mul_hex got %h want %h", hex, eh); end
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (k_update === 1'b1 || busy === 1'b1 || k !== K1000) act++;
        end
        checks++; if (act != 0) begin errors++; $display("FAIL rst_mul_after got %0d active cycles want 0", act); end
    endtask

    initial begin
        test_reset();
        test_step_down();
        test_preset();
        test_wrap_up();
        test_wrap_down();
        test_pending();
        test_multi_bit();
        test_both_keys();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
